// File: rtl/palette_encoder.sv
// palette_encoder: maps a 24-bit RGB pixel stream to 4-bit palette indices and writes them
// into the framebuffer. Optional macro PALETTE_NEAREST_EN enables nearest-colour fallback.
module palette_encoder #(
    parameter int unsigned FRAME_PIXELS = 2048,
    parameter logic [14:0] BASE_ADDR    = 15'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [23:0] pix_rgb,
    output logic        pix_ready,
    output logic        wr_en,
    output logic [14:0] wr_address,
    output logic [3:0]  wr_data,
    output logic        busy,
    output logic        frame_done
);
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned RGB_W      = 24;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned NUM_COLORS = 14;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);

    localparam logic [RGB_W-1:0] PALETTE [NUM_COLORS] = '{
        24'h000000, 24'h000066, 24'hFF0000, 24'hFF3200, 24'hFFFF00,
        24'h33FF00, 24'h009BFF, 24'h6D33FF, 24'hFFD393, 24'hFF99FF,
        24'hFF329F, 24'h999999, 24'hFF9999, 24'hFFFFFF
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [RGB_W-1:0]  rgb;
    } pix_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [ADDR_W-1:0] addr_ptr, addr_ptr_next;
    logic              pix_ready_next;
    logic              busy_next;
    logic              frame_done_next;
    logic              accept_c;

    logic              s1_valid;
    pix_t              s1_pix;
    logic              s2_valid;
    logic [ADDR_W-1:0] s2_addr;
    logic [IDX_W-1:0]  index_c;

    // pix_ready is a register that is high exactly while the FSM sits in RUN
    assign accept_c = pix_valid && pix_ready;

    // Control state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            addr_ptr   <= BASE_ADDR;
            pix_ready  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            addr_ptr   <= addr_ptr_next;
            pix_ready  <= pix_ready_next;
            busy       <= busy_next;
            frame_done <= frame_done_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        addr_ptr_next   = addr_ptr;
        frame_done_next = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next    = S_RUN;
                    cnt_next      = '0;
                    addr_ptr_next = BASE_ADDR;
                end
            end
            S_RUN: begin
                if (accept_c) begin
                    cnt_next      = cnt + CNT_W'(1);
                    addr_ptr_next = addr_ptr + ADDR_W'(1);
                    if (cnt == LAST_CNT) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The write now on the bus is the last one once both stages are empty
                if (wr_en && !s1_valid && !s2_valid) begin
                    state_next      = S_IDLE;
                    frame_done_next = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        pix_ready_next = (state_next == S_RUN);
        busy_next      = (state_next != S_IDLE);
    end

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Stage 1: capture the accepted pixel with its write address
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_pix <= '{addr: addr_ptr, rgb: pix_rgb};
            end
        end
    end

`ifdef PALETTE_NEAREST_EN
    localparam int unsigned DIST_W = 10;

    logic [DIST_W-1:0] dist_c  [NUM_COLORS];
    logic [DIST_W-1:0] s2_dist [NUM_COLORS];
    logic [DIST_W-1:0] best_c;

    // Manhattan distance to every palette entry; an exact match gives zero
    always_comb begin
        for (int i = 0; i < int'(NUM_COLORS); i++) begin
            dist_c[i] = DIST_W'(abs_diff(s1_pix.rgb[23:16], PALETTE[i][23:16]))
                      + DIST_W'(abs_diff(s1_pix.rgb[15:8],  PALETTE[i][15:8]))
                      + DIST_W'(abs_diff(s1_pix.rgb[7:0],   PALETTE[i][7:0]));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_COLORS); i++) begin
                s2_dist[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_COLORS); i++) begin
                s2_dist[i] <= dist_c[i];
            end
        end
    end

    // Strict less-than keeps the lowest index on ties
    always_comb begin
        index_c = '0;
        best_c  = s2_dist[0];
        for (int i = 1; i < int'(NUM_COLORS); i++) begin
            if (s2_dist[i] < best_c) begin
                best_c  = s2_dist[i];
                index_c = IDX_W'(i);
            end
        end
    end
`else
    logic [NUM_COLORS-1:0] match_c;
    logic [NUM_COLORS-1:0] s2_match;

    always_comb begin
        for (int i = 0; i < int'(NUM_COLORS); i++) begin
            match_c[i] = (s1_pix.rgb == PALETTE[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_match <= '0;
        end else begin
            s2_match <= match_c;
        end
    end

    // Non-matching pixels fall through to index 0
    always_comb begin
        index_c = '0;
        for (int i = int'(NUM_COLORS) - 1; i >= 0; i--) begin
            if (s2_match[i]) begin
                index_c = IDX_W'(i);
            end
        end
    end
`endif

    // Stage 2 and write port registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_valid   <= 1'b0;
            s2_addr    <= '0;
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
        end else begin
            s2_valid   <= s1_valid;
            s2_addr    <= s1_pix.addr;
            wr_en      <= s2_valid;
            wr_address <= s2_addr;
            wr_data    <= index_c;
        end
    end

endmodule

// File: tb/tb_palette_encoder.sv
// Directed table-driven bench for palette_encoder: four instances with different frame
// sizes and base addresses; writes and frame_done pulses are logged and scored.
`timescale 1ns/1ps
module tb_palette_encoder;
    localparam int NDUT = 4;

`ifdef PALETTE_NEAREST_EN
    localparam bit NEAREST = 1'b1;
`else
    localparam bit NEAREST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start      [NDUT];
    logic        pix_valid  [NDUT];
    logic [23:0] pix_rgb    [NDUT];
    logic        pix_ready  [NDUT];
    logic        wr_en      [NDUT];
    logic [14:0] wr_address [NDUT];
    logic [3:0]  wr_data    [NDUT];
    logic        busy       [NDUT];
    logic        frame_done [NDUT];

    always #5 clk = ~clk;

    // 0: 14 px @0, 1: 4 px @7FFE, 2: 2048 px @0, 3: 2 px @0
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned FP = (g == 0) ? 14 : (g == 1) ? 4 : (g == 2) ? 2048 : 2;
        localparam logic [14:0] BA = (g == 1) ? 15'h7FFE : 15'h0000;
        palette_encoder #(.FRAME_PIXELS(FP), .BASE_ADDR(BA)) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .start      (start[g]),
            .pix_valid  (pix_valid[g]),
            .pix_rgb    (pix_rgb[g]),
            .pix_ready  (pix_ready[g]),
            .wr_en      (wr_en[g]),
            .wr_address (wr_address[g]),
            .wr_data    (wr_data[g]),
            .busy       (busy[g]),
            .frame_done (frame_done[g])
        );
    end

    typedef struct {
        int d;
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct {
        int d;
        int cyc;
        int busy;
    } dn_t;

    typedef struct {
        bit          st;
        bit          valid;
        logic [23:0] rgb;
        logic [3:0]  idx_def;
        logic [3:0]  idx_near;
    } vec_t;

    int   cyc = 0;
    wr_t  wlog[$];
    dn_t  dlog[$];
    wr_t  exp_q[$];
    int   wpos = 0;
    int   dpos = 0;
    int   exp_k;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vt [36];

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write and frame_done pulse seen between edges
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (wr_en[d] === 1'b1)
                wlog.push_back('{d, int'(wr_address[d]), int'(wr_data[d]), cyc});
            if (frame_done[d] === 1'b1)
                dlog.push_back('{d, cyc, int'(busy[d])});
        end
    end

    function automatic vec_t mk(bit st, bit v, logic [23:0] rgb, logic [3:0] id, logic [3:0] inr);
        vec_t r;
        r.st = st; r.valid = v; r.rgb = rgb; r.idx_def = id; r.idx_near = inr;
        return r;
    endfunction

    function automatic logic [14:0] base_of(int d);
        return (d == 1) ? 15'h7FFE : 15'h0000;
    endfunction

    function automatic int outs(int d);
        return int'({pix_ready[d], wr_en[d], wr_address[d], wr_data[d], busy[d], frame_done[d]});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle at a negedge; a pixel expected to be accepted is due 3 negedges later
    task automatic drive_px(input int d, input bit st, input bit v, input logic [23:0] rgb,
                            input logic [3:0] idx, input bit acc);
        logic [14:0] a;
        start[d] = st;
        pix_valid[d] = v;
        pix_rgb[d] = rgb;
        if (acc) begin
            a = base_of(d) + 15'(exp_k);
            exp_q.push_back('{d, int'(a), int'(idx), cyc + 3});
            exp_k++;
        end
        @(negedge clk);
        start[d] = 1'b0;
        pix_valid[d] = 1'b0;
    endtask

    task automatic start_frame(input int d);
        exp_k = 0;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        check($sformatf("ready_after_start_d%0d", d), int'(pix_ready[d]), 1);
        check($sformatf("busy_after_start_d%0d", d), int'(busy[d]), 1);
    endtask

    task automatic run_vecs(input int d, input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            drive_px(d, vt[i].st, vt[i].valid, vt[i].rgb,
                     NEAREST ? vt[i].idx_near : vt[i].idx_def, vt[i].valid);
    endtask

    // Let the pipeline drain, then score writes and frame_done pulses since the last call
    task automatic finish_frame(input string name, input int d, input int n_done);
        int nw;
        int nd;
        repeat (6) @(negedge clk);
        nw = wlog.size() - wpos;
        nd = dlog.size() - dpos;
        check({name, "_write_count"}, nw, exp_q.size());
        for (int i = 0; i < nw && i < exp_q.size(); i++) begin
            check($sformatf("%s_dut_%0d", name, i),  wlog[wpos + i].d,    exp_q[i].d);
            check($sformatf("%s_addr_%0d", name, i), wlog[wpos + i].addr, exp_q[i].addr);
            check($sformatf("%s_data_%0d", name, i), wlog[wpos + i].data, exp_q[i].data);
            check($sformatf("%s_cyc_%0d", name, i),  wlog[wpos + i].cyc,  exp_q[i].cyc);
        end
        check({name, "_done_count"}, nd, n_done);
        if (n_done > 0 && nd > 0 && exp_q.size() > 0) begin
            check({name, "_done_dut"}, dlog[dlog.size() - 1].d, d);
            check({name, "_done_cyc"}, dlog[dlog.size() - 1].cyc, exp_q[exp_q.size() - 1].cyc + 1);
            check({name, "_done_busy"}, dlog[dlog.size() - 1].busy, 0);
        end
        check({name, "_idle_ready"}, int'(pix_ready[d]), 0);
        check({name, "_idle_busy"}, int'(busy[d]), 0);
        wpos = wlog.size();
        dpos = dlog.size();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Exact palette colours
        vt[0]  = mk(0, 1, 24'h000000, 4'h0, 4'h0);
        vt[1]  = mk(0, 1, 24'h000066, 4'h1, 4'h1);
        vt[2]  = mk(0, 1, 24'hFF0000, 4'h2, 4'h2);
        vt[3]  = mk(0, 1, 24'hFF3200, 4'h3, 4'h3);
        vt[4]  = mk(0, 1, 24'hFFFF00, 4'h4, 4'h4);
        vt[5]  = mk(0, 1, 24'h33FF00, 4'h5, 4'h5);
        vt[6]  = mk(0, 1, 24'h009BFF, 4'h6, 4'h6);
        vt[7]  = mk(0, 1, 24'h6D33FF, 4'h7, 4'h7);
        vt[8]  = mk(0, 1, 24'hFFD393, 4'h8, 4'h8);
        vt[9]  = mk(0, 1, 24'hFF99FF, 4'h9, 4'h9);
        vt[10] = mk(0, 1, 24'hFF329F, 4'hA, 4'hA);
        vt[11] = mk(0, 1, 24'h999999, 4'hB, 4'hB);
        vt[12] = mk(0, 1, 24'hFF9999, 4'hC, 4'hC);
        vt[13] = mk(0, 1, 24'hFFFFFF, 4'hD, 4'hD);
        // Mixed frame with a start pulse mid-frame; CC9999 and 000033 are ties
        vt[14] = mk(0, 1, 24'hFE0101, 4'h0, 4'h2);
        vt[15] = mk(0, 1, 24'h0A0A0A, 4'h0, 4'h0);
        vt[16] = mk(0, 1, 24'h808080, 4'h0, 4'hB);
        vt[17] = mk(0, 1, 24'hCC9999, 4'h0, 4'hB);
        vt[18] = mk(0, 1, 24'hFEFFFF, 4'h0, 4'hD);
        vt[19] = mk(1, 1, 24'h000033, 4'h0, 4'h0);
        vt[20] = mk(0, 1, 24'h6D33FF, 4'h7, 4'h7);
        vt[21] = mk(0, 1, 24'hFFD393, 4'h8, 4'h8);
        vt[22] = mk(0, 1, 24'h000066, 4'h1, 4'h1);
        vt[23] = mk(0, 1, 24'hFF329F, 4'hA, 4'hA);
        vt[24] = mk(0, 1, 24'h999999, 4'hB, 4'hB);
        vt[25] = mk(0, 1, 24'hFF3201, 4'h0, 4'h3);
        vt[26] = mk(0, 1, 24'hFFFFFF, 4'hD, 4'hD);
        vt[27] = mk(0, 1, 24'h010000, 4'h0, 4'h0);
        // Gaps and address wrap
        vt[28] = mk(0, 1, 24'hFF0000, 4'h2, 4'h2);
        vt[29] = mk(0, 0, 24'h999999, 4'h0, 4'h0);
        vt[30] = mk(0, 1, 24'h33FF00, 4'h5, 4'h5);
        vt[31] = mk(0, 1, 24'h009BFF, 4'h6, 4'h6);
        vt[32] = mk(0, 0, 24'hFFFFFF, 4'h0, 4'h0);
        vt[33] = mk(0, 1, 24'hFFFF00, 4'h4, 4'h4);
        // Unmatched colours
        vt[34] = mk(0, 1, 24'hFE0101, 4'h0, 4'h2);
        vt[35] = mk(0, 1, 24'h0A0A0A, 4'h0, 4'h0);

        reset_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            start[d] = 1'b0;
            pix_valid[d] = 1'b0;
            pix_rgb[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++)
            check($sformatf("reset_outputs_d%0d", d), outs(d), 0);
        reset_n = 1'b1;
        wpos = wlog.size();
        dpos = dlog.size();

        start_frame(0);
        run_vecs(0, 0, 13);
        finish_frame("exact", 0, 1);

        // Two back-to-back short frames, the second started in the frame_done cycle
        start_frame(3);
        run_vecs(3, 34, 35);
        repeat (3) @(negedge clk);
        check("done_before_restart", int'(frame_done[3]), 1);
        start_frame(3);
        run_vecs(3, 34, 35);
        finish_frame("unmatched", 3, 2);

        start_frame(1);
        run_vecs(1, 28, 33);
        finish_frame("gaps_wrap", 1, 1);

        start_frame(0);
        run_vecs(0, 14, 27);
        finish_frame("ignored_start", 0, 1);

        // Full 2048-pixel frame with pix_valid held high past the end
        start_frame(2);
        for (int k = 0; k < 2048; k++)
            drive_px(2, 1'b0, 1'b1, vt[k % 14].rgb, vt[k % 14].idx_def, 1'b1);
        check("boundary_ready_low", int'(pix_ready[2]), 0);
        for (int k = 0; k < 4; k++)
            drive_px(2, 1'b0, 1'b1, 24'hFFFFFF, 4'hD, 1'b0);
        if (wlog.size() > wpos)
            check("boundary_last_addr", wlog[wlog.size() - 1].addr, 15'h07FF);
        finish_frame("boundary", 2, 1);

        // Reset after five acceptances: only the three writes already out survive
        start_frame(0);
        for (int i = 0; i < 5; i++)
            drive_px(0, 1'b0, 1'b1, vt[i].rgb, vt[i].idx_def, 1'b1);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("reset_mid_outputs", outs(0), 0);
        finish_frame("reset_mid", 0, 0);

        start_frame(0);
        run_vecs(0, 0, 13);
        finish_frame("restart", 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/palette_encoder.md
# palette_encoder

Writer side of the LED-panel framebuffer path: accepts a stream of 24-bit RGB pixels, maps each pixel to a 4-bit palette index, and writes the index into the 15-bit-addressed framebuffer memory. It is the write-side counterpart of the block that reads the same memory and expands indices back to RGB for the upper and lower panel halves. A frame is FRAME_PIXELS consecutive addresses from BASE_ADDR:
- upper half: BASE_ADDR .. BASE_ADDR+1023
- lower half: BASE_ADDR+1024 upward

## Interface
- FRAME_PIXELS, 2048: pixels written per frame; legal range 1..32768.
- BASE_ADDR, 0: memory address of the first pixel (15-bit).
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- pix_valid  in  1  pix_rgb holds a pixel.
- pix_rgb  in  24  pixel, {R[23:16], G[15:8], B[7:0]}.
- pix_ready  out  1  block can accept a pixel this cycle.
- wr_en  out  1  memory write strobe, one cycle per pixel.
- wr_address  out  15  memory write address.
- wr_data  out  4  palette index.
- busy  out  1  high in RUN and DRAIN.
- frame_done  out  1  one-cycle pulse after the last write of a frame.

## Operation
- Palette, index:RGB hex:
  - 0:000000, 1:000066, 2:FF0000, 3:FF3200, 4:FFFF00
  - 5:33FF00, 6:009BFF, 7:6D33FF, 8:FFD393, 9:FF99FF
  - A:FF329F, B:999999, C:FF9999, D:FFFFFF
  - Indices E and F are never written.
- A pixel that exactly matches an entry encodes to that index. Non-match handling is set under Configuration.
- A pixel is accepted on a rising edge where pix_valid && pix_ready.
- FSM states and transitions:
  - IDLE: pix_ready=0, busy=0. start=1 → RUN; clears pixel counter cnt.
  - RUN: pix_ready=1 while cnt < FRAME_PIXELS. Each acceptance increments cnt. When the acceptance with cnt == FRAME_PIXELS-1 occurs, go to DRAIN; pix_ready drops in the next cycle.
  - DRAIN: pix_ready=0. Wait until the pipeline is empty (last wr_en issued), then pulse frame_done and go to IDLE.
- start is ignored in RUN and DRAIN. Pixels offered in IDLE or DRAIN are not accepted.
- Write address = BASE_ADDR + k for the k-th accepted pixel (k from 0). Modulo-2^15 addition: addresses wrap from 0x7FFF to 0x0000.
- pix_valid gaps in RUN stall the counter. They produce wr_en=0 cycles; no write is issued for a gap.
- There is no backpressure from memory: every accepted pixel produces exactly one write.

## Timing
- Reset (reset_n=0 at a rising edge) forces, from the next cycle:
  - pix_ready=0, wr_en=0, wr_address=0, wr_data=0, busy=0, frame_done=0
  - state IDLE, cnt=0, pipeline cleared
- Reset mid-frame abandons the frame: no further writes, no frame_done.
- Pipeline is 2 registered stages with latency 2: a pixel accepted at edge N gives wr_en=1 with its wr_address/wr_data during the cycle after edge N+2.
- Throughput is one pixel per clock. Back-to-back acceptances give back-to-back wr_en.
- pix_ready in RUN is a registered/state-derived signal with no combinational path from pix_valid.
- frame_done is high in the cycle immediately after the final wr_en cycle.
- busy falls in the same cycle frame_done is high.
- Earliest next frame: start is accepted in the cycle frame_done is high; that frame's first pixel can be accepted the following cycle.

## Configuration
- PALETTE_NEAREST_EN defined: a non-matching pixel encodes to the index of minimum distance |dR|+|dG|+|dB| (10-bit unsigned sum) over indices 0..D. Ties go to the lowest index.
- PALETTE_NEAREST_EN undefined: a non-matching pixel encodes to index 0.
- Latency and throughput are identical in both builds.

## Test plan
- Exact colours: start, then stream all 14 palette colours (FRAME_PIXELS=14, BASE_ADDR=0) → wr_data 0..D at addresses 0..13, latency 2, frame_done one cycle after the last write.
- Unmatched colour: FRAME_PIXELS=2, pixels 0xFE0101 then 0x0A0A0A → wr_data 0,0 without the macro; 2,0 with PALETTE_NEAREST_EN.
- Gaps and wrap: BASE_ADDR=0x7FFE, FRAME_PIXELS=4, pix_valid toggling 1,0,1,1,0,1 → addresses 7FFE,7FFF,0000,0001; exactly 4 wr_en pulses; no write in gap cycles.
- Frame boundary: FRAME_PIXELS=2048 with pix_valid held high → pix_ready low after 2048 acceptances, last address 0x07FF, frame_done single-cycle pulse, extra pixels not accepted.
- Ignored start: start pulsed mid-frame → cnt and addresses unaffected; exactly one frame_done.
- Reset mid-frame: reset_n low for 1 cycle after 5 acceptances → all outputs 0 next cycle, no frame_done; a new start resumes at BASE_ADDR.
